fifo_rd_stream: RTL

- Downstream drain stage for the 8-bit, 16-entry synchronous FIFO.
- Issues the FIFO's read enable and captures read data, which the FIFO returns one cycle after the read.
- Re-times the data through a 2-entry skid buffer onto a valid/ready stream.
- Groups beats into fixed-length frames, marked by m_last, and counts completed frames.

---
 rtl/fifo_rd_stream_pkg.sv | 14 +
 rtl/fifo_rd_stream_rd_skid_buf.sv | 48 ++++
 rtl/fifo_rd_stream.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream stage: FSM encoding and default sizes.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry skid buffer holding captured FIFO beats until the stream sink accepts them.
module rd_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: the two slots are reset as well, so the stream data reads zero after reset
  // instead of whatever the storage powered up with.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // A push never lands on the head while it is visible: with one entry stored the
  // write pointer is on the other slot, and a full buffer is never pushed.
  assign head = slot[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drain stage: issues FIFO reads, re-times data through a skid buffer onto a framed valid/ready stream.
// Optional per-beat even parity output is built when RD_STREAM_PARITY_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
`ifdef RD_STREAM_PARITY_EN
  output logic                  m_parity,
`endif
  output logic                  busy,
  output logic [FCNT_WIDTH-1:0] frame_cnt
);

`ifdef RD_STREAM_PARITY_EN
  localparam int PW = DATA_WIDTH + 2;
`else
  localparam int PW = DATA_WIDTH + 1;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    beat_cnt;
  logic          inflight;
  logic          inflight_last;
  logic          issue_ok;
  logic          last_tag;
  logic          rd_issue;
  logic          pop;
  logic [2:0]    credit_sum;
  logic [1:0]    occ;
  logic [PW-1:0] head;
  logic [PW-1:0] push_payload;

  assign last_tag = (beat_cnt == 8'(BURST_LEN - 1));
  assign pop      = m_valid & m_ready;

  // Credit counts stored plus in-flight beats; a beat leaving this cycle frees its
  // slot in time for the read issued now, which is what sustains one beat per cycle.
  assign credit_sum = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_issue   = issue_ok & ~fifo_empty & (credit_sum < 3'd2);
  assign fifo_rd_en = rd_issue;

`ifdef RD_STREAM_PARITY_EN
  assign push_payload = {^fifo_data, inflight_last, fifo_data};
  assign m_parity     = head[DATA_WIDTH+1];
`else
  assign push_payload = {inflight_last, fifo_data};
`endif

  rd_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(push_payload),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[DATA_WIDTH-1:0];
  assign m_last  = head[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      beat_cnt      <= 8'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      inflight      <= rd_issue;
      inflight_last <= last_tag;
      if (rd_issue) begin
        beat_cnt <= last_tag ? 8'd0 : beat_cnt + 8'd1;
      end
      if (pop && m_last) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: defaulting to the current state first means no path leaves state_nxt
    // unassigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en) begin
          if (rd_issue && last_tag)               state_nxt = S_FLUSH;
          else if (beat_cnt == 8'd0 && !rd_issue) state_nxt = S_IDLE;
          else                                    state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_issue && last_tag) state_nxt = en ? S_RUN : S_FLUSH;
      end
      S_FLUSH: begin
        if (en)                             state_nxt = S_RUN;
        else if (occ == 2'd0 && !inflight)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ok = (state == S_RUN) || (state == S_DRAIN);
    busy     = (state != S_IDLE);
  end

endmodule
